// File: rtl/exception_handler_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, exception_type bit indices,
// Status/Cause field positions and reset/vector defaults.
package exception_handler_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C,
        EXC_TR   = 5'h0D
    } exc_code_e;

    localparam int ET_IF      = 0;
    localparam int ET_RI      = 1;
    localparam int ET_OV      = 2;
    localparam int ET_TP      = 3;
    localparam int ET_BREAK   = 4;
    localparam int ET_SYSCALL = 5;
    localparam int ET_ADE     = 6;
    localparam int ET_ERET    = 7;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_BD     = 31;
    localparam int CA_IP_LO  = 8;
    localparam int CA_EXC_LO = 2;

    // Software-writable Status bits: IM[15:8], EXL, IE.
    localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;

    localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC00380;
    localparam logic [31:0] STATUS_RESET_DEF = 32'h0040FF00;

endpackage

// File: rtl/exception_handler_cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, timer_int latches on
// a Count==Compare match (Compare nonzero) and clears on any Compare write.
import exception_handler_pkg::*;

module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        toggle_r;
    logic        timer_int_r;

    // Count/toggle/Compare registers and the sticky timer interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 32'd0;
            compare_r   <= 32'd0;
            toggle_r    <= 1'b0;
            timer_int_r <= 1'b0;
        end else begin
            if (count_we) begin
                count_r  <= wdata;
                toggle_r <= 1'b0;
            end else begin
                toggle_r <= ~toggle_r;
                count_r  <= toggle_r ? count_r + 32'd1 : count_r;
            end
            // A Compare write beats a coincident match.
            if (compare_we) begin
                compare_r   <= wdata;
                timer_int_r <= 1'b0;
            end else if ((count_r == compare_r) && (compare_r != 32'd0)) begin
                timer_int_r <= 1'b1;
            end else begin
                timer_int_r <= timer_int_r;
            end
        end
    end

    assign count     = count_r;
    assign compare   = compare_r;
    assign timer_int = timer_int_r;

endmodule

// File: rtl/exception_handler.sv
// MEM-stage exception/interrupt resolution and CP0 register file.
// Optional Count/Compare timer is built when TIMER_INT_EN is defined.
import exception_handler_pkg::*;

module exception_handler #(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RESET = STATUS_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  exception_type,
    input  logic        inst_valid,
    input  logic [31:0] pc,
    input  logic        delay_slot,
    input  logic        alu_overflow,
    input  logic [31:0] mem_addr,
    input  logic        mem_write,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    input  logic [5:0]  hw_int,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] exc_pc,
    output logic        timer_int
);

    logic [31:0] status_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic        cause_bd_r;
    logic [4:0]  cause_exc_r;
    logic [1:0]  sw_ip_r;
    logic [5:0]  hw_ip_r;

    logic [7:0]  ip_s;
    logic        int_pending_s;
    logic        take_s;
    logic        eret_s;
    logic        flush_s;
    exc_code_e   code_s;
    logic        badv_we_s;
    logic [31:0] badv_val_s;
    logic        mtc0_ok_s;
    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        timer_int_s;

    assign mtc0_ok_s = cp0_we & ~flush_s & ~rst;

`ifdef TIMER_INT_EN
    cp0_timer u_cp0_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_ok_s & (cp0_waddr == CP0_COUNT)),
        .compare_we (mtc0_ok_s & (cp0_waddr == CP0_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count_s),
        .compare    (compare_s),
        .timer_int  (timer_int_s)
    );
`else
    assign count_s     = 32'd0;
    assign compare_s   = 32'd0;
    assign timer_int_s = 1'b0;
`endif

    assign ip_s          = {hw_ip_r[5] | timer_int_s, hw_ip_r[4:0], sw_ip_r};
    assign int_pending_s = status_r[ST_IE] & ~status_r[ST_EXL]
                         & (|(ip_s & status_r[ST_IM_LO +: 8]));

    // Priority resolution; interrupts are taken only on a real instruction so EPC is meaningful.
    always_comb begin
        take_s     = 1'b0;
        eret_s     = 1'b0;
        code_s     = EXC_INT;
        badv_we_s  = 1'b0;
        badv_val_s = 32'd0;
        if (!rst && inst_valid) begin
            if (int_pending_s) begin
                take_s = 1'b1;
                code_s = EXC_INT;
            end else if (exception_type[ET_IF]) begin
                take_s     = 1'b1;
                code_s     = EXC_ADEL;
                badv_we_s  = 1'b1;
                badv_val_s = pc;
            end else if (exception_type[ET_RI]) begin
                take_s = 1'b1;
                code_s = EXC_RI;
            end else if (exception_type[ET_OV] && alu_overflow) begin
                take_s = 1'b1;
                code_s = EXC_OV;
            end else if (exception_type[ET_TP]) begin
                take_s = 1'b1;
                code_s = EXC_TR;
            end else if (exception_type[ET_SYSCALL]) begin
                take_s = 1'b1;
                code_s = EXC_SYS;
            end else if (exception_type[ET_BREAK]) begin
                take_s = 1'b1;
                code_s = EXC_BP;
            end else if (exception_type[ET_ADE]) begin
                take_s     = 1'b1;
                code_s     = mem_write ? EXC_ADES : EXC_ADEL;
                badv_we_s  = 1'b1;
                badv_val_s = mem_addr;
            end else if (exception_type[ET_ERET]) begin
                eret_s = 1'b1;
            end else begin
                take_s = 1'b0;
            end
        end else begin
            take_s = 1'b0;
        end
    end

    assign flush_s = take_s | eret_s;
    assign flush   = flush_s;
    assign exc_pc  = take_s ? EXC_VECTOR : (eret_s ? epc_r : 32'd0);
    assign timer_int = timer_int_s;

    // CP0 state update: exception entry, ERET, then MTC0 (suppressed on flush).
    always_ff @(posedge clk) begin
        if (rst) begin
            status_r    <= STATUS_RESET;
            epc_r       <= 32'd0;
            badvaddr_r  <= 32'd0;
            cause_bd_r  <= 1'b0;
            cause_exc_r <= 5'd0;
            sw_ip_r     <= 2'd0;
            hw_ip_r     <= 6'd0;
        end else begin
            hw_ip_r <= hw_int;
            if (take_s) begin
                if (!status_r[ST_EXL]) begin
                    epc_r      <= delay_slot ? pc - 32'd4 : pc;
                    cause_bd_r <= delay_slot;
                end
                cause_exc_r      <= code_s;
                status_r[ST_EXL] <= 1'b1;
                if (badv_we_s) begin
                    badvaddr_r <= badv_val_s;
                end
            end else if (eret_s) begin
                status_r[ST_EXL] <= 1'b0;
            end else if (mtc0_ok_s) begin
                case (cp0_waddr)
                    CP0_STATUS: status_r <= (status_r & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
                    CP0_CAUSE:  sw_ip_r  <= cp0_wdata[CA_IP_LO +: 2];
                    CP0_EPC:    epc_r    <= cp0_wdata;
                    default:    epc_r    <= epc_r;
                endcase
            end else begin
                epc_r <= epc_r;
            end
        end
    end

    // MFC0 read mux; unimplemented registers read as zero.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_r;
            CP0_COUNT:    cp0_rdata = count_s;
            CP0_COMPARE:  cp0_rdata = compare_s;
            CP0_STATUS:   cp0_rdata = status_r;
            CP0_CAUSE:    cp0_rdata = {cause_bd_r, 15'd0, ip_s, 1'b0, cause_exc_r, 2'b00};
            CP0_EPC:      cp0_rdata = epc_r;
            default:      cp0_rdata = 32'd0;
        endcase
    end

endmodule
